// File: rtl/iobus_uart_tx.sv
// -----------------------------------------------------------------------------
// iobus_uart_tx
//
// Memory-mapped 8N1 UART transmitter on the Otter CPU IO bus. Stores to
// TX_ADDR queue a byte in a small circular FIFO; a transmit FSM pops bytes
// and serialises them LSB first on TX. A status word is returned on IOBUS_IN
// whenever the CPU addresses STAT_ADDR; a store to STAT_ADDR with bit 0 set
// clears the sticky overflow flag.
//
// Ports:
//   CLK         system clock, rising edge
//   RST         synchronous reset, active low
//   IOBUS_ADDR  CPU IO address
//   IOBUS_OUT   CPU write data (byte in [7:0] for TX_ADDR, clear in [0] for STAT_ADDR)
//   IOBUS_WR    CPU write strobe, one cycle per store
//   IOBUS_IN    read data to CPU (combinational):
//               STAT_ADDR -> {23'b0, overflow, busy, empty, full, count[4:0]}
//               otherwise -> 0
//   TX          serial line, idle high
// -----------------------------------------------------------------------------
module iobus_uart_tx #(
  parameter logic [31:0] TX_ADDR      = 32'h1100_0040,
  parameter logic [31:0] STAT_ADDR    = 32'h1100_0044,
  parameter int unsigned CLKS_PER_BIT = 217,  // 2 .. 65535
  parameter int unsigned FIFO_DEPTH   = 8     // power of two, 2 .. 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] IOBUS_ADDR,
  input  logic [31:0] IOBUS_OUT,
  input  logic        IOBUS_WR,
  output logic [31:0] IOBUS_IN,
  output logic        TX
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;          // holds 0 .. FIFO_DEPTH
  localparam int BAUD_W = 16;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  // ---------------------------------------------------------------------------
  // Storage and state
  // ---------------------------------------------------------------------------
  logic [7:0]        fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;

  state_t            state;
  logic [BAUD_W-1:0] baud_cnt;
  logic [2:0]        bit_idx;
  logic [7:0]        shift;
  logic              tx_q;
  logic              overflow;

  // ---------------------------------------------------------------------------
  // Bus decode and FIFO handshakes
  // ---------------------------------------------------------------------------
  logic wr_data;
  logic wr_stat;
  logic fifo_empty;
  logic fifo_full;
  logic pop;
  logic push;
  logic drop;
  logic busy;

  assign wr_data    = IOBUS_WR && (IOBUS_ADDR == TX_ADDR);
  assign wr_stat    = IOBUS_WR && (IOBUS_ADDR == STAT_ADDR);
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == DEPTH_C);
  assign busy       = (state != IDLE);

  // The FSM only ever takes a byte out of the FIFO from IDLE.
  assign pop  = (state == IDLE) && !fifo_empty;
  // A full FIFO can still accept a byte on the edge that frees a slot.
  assign push = wr_data && (!fifo_full || pop);
  assign drop = wr_data && !push;

  // Only the low byte carries data; the rest of the write word is don't-care.
  logic unused_wdata;
  assign unused_wdata = ^IOBUS_OUT[31:8];

  // ---------------------------------------------------------------------------
  // FIFO payload
  // ---------------------------------------------------------------------------
  // NOTE: the byte array carries no reset; a slot is only ever read after it
  // has been written, and leaving it out of reset keeps it a plain RAM.
  always_ff @(posedge CLK) begin
    if (push) begin
      fifo_mem[wr_ptr] <= IOBUS_OUT[7:0];
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO pointers, occupancy and sticky overflow
  // ---------------------------------------------------------------------------
  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;

      unique case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase

      // A drop on the same edge as a clear leaves the flag set.
      if (drop) begin
        overflow <= 1'b1;
      end else if (wr_stat && IOBUS_OUT[0]) begin
        overflow <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Transmit FSM
  //
  // TX is registered and updated on the same edge as the state change, so the
  // start bit appears right after the pop edge and a frame occupies exactly
  // 10*CLKS_PER_BIT cycles from pop to re-entry into IDLE. Back-to-back frames
  // therefore see one extra IDLE cycle of TX=1 before the next pop.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      tx_q     <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          tx_q <= 1'b1;
          if (pop) begin
            shift    <= fifo_mem[rd_ptr];
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx_q     <= 1'b0;
            state    <= START;
          end
        end

        START: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx_q     <= shift[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        DATA: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            shift    <= shift >> 1;
            if (bit_idx == 3'd7) begin
              tx_q  <= 1'b1;
              state <= STOP;
            end else begin
              // shift[1] is the bit that becomes shift[0] after this edge.
              bit_idx <= bit_idx + 1'b1;
              tx_q    <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        STOP: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            tx_q     <= 1'b1;
            state    <= IDLE;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        default: begin
          baud_cnt <= '0;
          tx_q     <= 1'b1;
          state    <= IDLE;
        end
      endcase
    end
  end

  assign TX = tx_q;

  // ---------------------------------------------------------------------------
  // Status read-back
  // ---------------------------------------------------------------------------
  // NOTE: IOBUS_IN is assigned a default before the address test so no path
  // through the block leaves it unassigned, which would infer a latch.
  always_comb begin
    IOBUS_IN = '0;
    if (IOBUS_ADDR == STAT_ADDR) begin
      IOBUS_IN[4:0] = 5'(count);
      IOBUS_IN[5]   = fifo_full;
      IOBUS_IN[6]   = fifo_empty;
      IOBUS_IN[7]   = busy;
      IOBUS_IN[8]   = overflow;
    end
  end

endmodule

// File: tb/tb_iobus_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_iobus_uart_tx
//
// Self-checking bench for iobus_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=8.
// The reference model is transaction level: a byte queue plus "cycles since
// the current frame was popped"; expected TX is the 10-bit frame
// {stop, data, start} indexed by elapsed_cycles / CLKS_PER_BIT. Every cycle
// TX and IOBUS_IN are compared against the model on the falling edge.
// -----------------------------------------------------------------------------
module tb_iobus_uart_tx;

  localparam int          CPB     = 4;
  localparam int          DEPTH   = 8;
  localparam int          FRAME   = 10 * CPB;
  localparam logic [31:0] TX_A    = 32'h1100_0040;
  localparam logic [31:0] STAT_A  = 32'h1100_0044;
  localparam logic [31:0] OTHER_A = 32'h1100_0048;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        wr;
  logic [31:0] rdata;
  logic        tx;

  always #5 clk = ~clk;

  iobus_uart_tx #(
    .TX_ADDR     (TX_A),
    .STAT_ADDR   (STAT_A),
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .CLK       (clk),
    .RST       (rst),
    .IOBUS_ADDR(addr),
    .IOBUS_OUT (wdata),
    .IOBUS_WR  (wr),
    .IOBUS_IN  (rdata),
    .TX        (tx)
  );

  int    checks = 0;
  int    errors = 0;
  string phase  = "reset";

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s.%s got=%08h exp=%08h at %0t", phase, tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  logic [7:0] q[$];
  bit         m_busy = 1'b0;
  int         m_t    = 0;     // cycles since the frame's pop edge
  bit [9:0]   m_frame = '1;
  bit         m_ovf  = 1'b0;

  // Advance the model by one rising edge using the inputs present at it.
  function automatic void model_edge();
    int         pre_cnt;
    bit         pre_busy;
    bit         pop;
    bit         dropped;
    logic [7:0] b;
    if (!rst) begin
      q.delete();
      m_busy = 1'b0;
      m_t    = 0;
      m_ovf  = 1'b0;
      return;
    end
    pre_cnt  = q.size();
    pre_busy = m_busy;
    pop      = !pre_busy && (pre_cnt > 0);
    dropped  = 1'b0;
    if (m_busy) begin
      m_t++;
      if (m_t == FRAME) m_busy = 1'b0;
    end
    if (pop) begin
      b       = q.pop_front();
      m_frame = {1'b1, b, 1'b0};
      m_t     = 0;
      m_busy  = 1'b1;
    end
    if (wr && addr == TX_A) begin
      if (pre_cnt < DEPTH || pop) q.push_back(wdata[7:0]);
      else begin
        dropped = 1'b1;
        m_ovf   = 1'b1;
      end
    end
    if (wr && addr == STAT_A && wdata[0] && !dropped) m_ovf = 1'b0;
  endfunction

  function automatic logic exp_tx();
    return m_busy ? m_frame[m_t / CPB] : 1'b1;
  endfunction

  function automatic logic [31:0] exp_in();
    logic [31:0] v;
    int          n;
    v = '0;
    n = q.size();
    if (addr == STAT_A) begin
      v[4:0] = 5'(n);
      v[5]   = (n == DEPTH);
      v[6]   = (n == 0);
      v[7]   = m_busy;
      v[8]   = m_ovf;
    end
    return v;
  endfunction

  // ---------------------------------------------------------------------------
  // Stimulus helpers: inputs change on the falling edge, outputs are checked
  // on the falling edge after the model has absorbed the rising edge.
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("tx", {31'd0, tx}, {31'd0, exp_tx()});
    check("iobus_in", rdata, exp_in());
  endtask

  task automatic idle(input int n);
    wr   = 1'b0;
    addr = STAT_A;
    repeat (n) tick();
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    wr    = 1'b1;
    tick();
    wr    = 1'b0;
    addr  = STAT_A;
  endtask

  int  r;
  int  thresh;
  bit  found;

  initial begin
    rst   = 1'b0;
    wr    = 1'b0;
    addr  = STAT_A;
    wdata = '0;

    // Reset state
    repeat (3) tick();
    rst = 1'b1;
    #1 check("reset_status", rdata, 32'h0000_0040);
    check("reset_tx", {31'd0, tx}, 32'd1);
    idle(4);

    // Single frame; upper write bits are ignored
    phase = "single";
    bus_write(TX_A, 32'hFFFF_FFA5);
    idle(1);
    check("single_startbit", {31'd0, tx}, 32'd0);
    idle(FRAME + 4);

    // Three consecutive writes -> three back-to-back frames
    phase = "three";
    bus_write(TX_A, 32'h01);
    bus_write(TX_A, 32'h02);
    bus_write(TX_A, 32'h03);
    #1 check("three_count_peak", rdata, 32'h0000_0082);
    idle(3 * (FRAME + 1) + 4);

    // Ten consecutive writes -> 8 queued, one in flight, one dropped
    phase = "overflow";
    for (int i = 0; i < 10; i++) bus_write(TX_A, $urandom);
    #1 check("ovf_full_status", rdata, 32'h0000_01A8);
    idle(2);
    bus_write(STAT_A, 32'h1);
    #1 check("ovf_cleared", rdata, 32'h0000_00A8);

    // Push to a full FIFO on the edge the FSM pops
    phase = "full_pop";
    found = 1'b0;
    for (int i = 0; i < 4 * FRAME; i++) begin
      if (!m_busy && q.size() == DEPTH) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check("wait_full_idle", {31'd0, found}, 32'd1);
    bus_write(TX_A, $urandom);
    #1 check("full_pop_status", rdata, 32'h0000_00A8);
    idle((DEPTH + 1) * (FRAME + 1) + 4);

    // Randomised bus traffic: busy phase then sparse phase
    phase = "random";
    for (int i = 0; i < 1600; i++) begin
      thresh = (i < 800) ? 3 : 1;
      r = $urandom_range(0, 19);
      if (r < thresh)       bus_write(TX_A, $urandom);
      else if (r == 3)      bus_write(STAT_A, $urandom);
      else if (r == 4)      bus_write(OTHER_A, $urandom);
      else begin
        wr   = 1'b0;
        addr = (r < 12) ? STAT_A : ((r < 16) ? TX_A : OTHER_A);
        tick();
      end
    end

    // Reset in the middle of a data bit
    phase = "midreset";
    bus_write(TX_A, $urandom);
    bus_write(TX_A, $urandom);
    found = 1'b0;
    for (int i = 0; i < 20 * FRAME; i++) begin
      if (m_busy && m_t >= CPB + 1 && m_t < 9 * CPB) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check("wait_data_bit", {31'd0, found}, 32'd1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    #1 check("midreset_status", rdata, 32'h0000_0040);
    check("midreset_tx", {31'd0, tx}, 32'd1);
    idle(3 * FRAME);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/iobus_uart_tx.md
Name: iobus_uart_tx

Overview:
- Memory-mapped UART transmitter that sits directly downstream of the Otter CPU and consumes its IOBUS write port (IOBUS_ADDR, IOBUS_OUT, IOBUS_WR).
- Writes to a data address are queued in a small FIFO and serialized 8N1 on TX.
- A status word is driven back to the CPU on IOBUS_IN.
- Gives the pipelined core a real output peripheral in place of a tied-off IO bus.

Parameters:
- TX_ADDR, 32'h1100_0040, data register address; write pushes IOBUS_OUT[7:0].
- STAT_ADDR, 32'h1100_0044, status register address; read status, write clears overflow.
- CLKS_PER_BIT, 217, clock cycles per serial bit (25 MHz / 115200); legal range 2 to 65535.
- FIFO_DEPTH, 8, byte entries; power of two, 2 to 16.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  synchronous active-low reset; sampled on CLK rising edge.
- IOBUS_ADDR  input  32  CPU IO address.
- IOBUS_OUT  input  32  CPU write data.
- IOBUS_WR  input  1  CPU write strobe, one cycle per store.
- IOBUS_IN  output  32  read data to CPU; combinational.
- TX  output  1  serial line, idle high.

Behaviour:
- Reset (RST==0 at an edge): FIFO empty, FSM IDLE, baud and bit counters 0, overflow=0, TX=1.
  - Applies mid-frame: the frame is aborted, TX is 1 after that edge and queued bytes are discarded.
- Push:
  - Condition: IOBUS_WR=1 and IOBUS_ADDR==TX_ADDR at an edge.
  - Enqueues IOBUS_OUT[7:0]; bits [31:8] are ignored.
  - Accepted if count<FIFO_DEPTH, or if the FSM pops on the same edge.
  - Otherwise the byte is dropped and overflow is set (sticky).
- Clear: IOBUS_WR=1, IOBUS_ADDR==STAT_ADDR, IOBUS_OUT[0]=1 clears overflow. If a drop occurs on the same edge, set wins.
- Writes to any other address are ignored.
- IOBUS_IN:
  - When IOBUS_ADDR==STAT_ADDR: [4:0]=count, [5]=full, [6]=empty, [7]=busy (FSM not IDLE), [8]=overflow, [31:9]=0.
  - Otherwise IOBUS_IN=0. No read side effects.
- FIFO: circular, pointer width log2(FIFO_DEPTH), wraps modulo depth. Count is held separately so full and empty are unambiguous.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: TX=1. If FIFO non-empty at an edge, pop head into shift register, clear baud counter, go START.
  - START: TX=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
  - DATA: TX=shift[0] for CLKS_PER_BIT cycles per bit, LSB first. Shift right after each bit; after bit 7 go STOP.
  - STOP: TX=1 for CLKS_PER_BIT cycles, then IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1; the terminal count advances the state or bit index.
- Timing:
  - Push sampled at edge k with FIFO empty and FSM IDLE: count=1 after edge k; pop at edge k+1; TX falls after edge k+1.
  - Frame is exactly 10*CLKS_PER_BIT cycles.
  - Back-to-back frames are separated by exactly one IDLE cycle of TX=1 (stop bit lasts CLKS_PER_BIT+1 cycles).
- Busy: high from the pop edge until re-entry to IDLE.

Test Plan:
- Reset, then hold RST=1, CLKS_PER_BIT=4: TX=1, IOBUS_IN at STAT_ADDR = 32'h0000_0040 (empty).
- Write 32'hFFFF_FFA5 to TX_ADDR -> TX low 2nd edge after write for 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then stop high; total 40 cycles; busy=1 throughout.
- Write 3 bytes 8'h01, 8'h02, 8'h03 on consecutive cycles -> count peaks at 2 after first pop, three frames, each separated by exactly 1 idle cycle, bytes in order.
- With DEPTH=8, 10 writes on consecutive cycles -> after the first pop 8 further bytes are queued and the 10th write is dropped; status shows full=1, count=8, overflow=1. Write 1 to STAT_ADDR -> overflow=0.
- Push to a full FIFO on the same edge the FSM pops -> byte accepted, count unchanged at 8, overflow stays 0.
- Assert RST=0 for one edge mid-DATA -> TX=1 next cycle, status 32'h0000_0040, no further frames emitted.
